prog_loader: RTL and testbench

Host-side transmitter for the FSM instruction memory's serial programming port. It accepts program bytes over a valid/ready stream and serializes them MSB-first into INPUT_WIDTH-bit chunks on prog_enable/prog_data. It counts exactly MEM_WIDTH shifted bits, then reports completion. It sits between the chip-level host interface (SPI/pad bytes) and the instruction memory shift register.

---
 rtl/prog_pkg.sv | 45 ++++
 rtl/prog_serializer.sv | 40 ++++
 rtl/prog_loader.sv | 137 +++++++++++++
 tb/tb_prog_loader.sv | 320 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/prog_pkg.sv
// Shared definitions for the instruction-memory programming path: loader FSM
// states and the program image size, which the instruction memory computes
// with the same function so the two sides cannot disagree.
package prog_pkg;

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    WAIT_BYTE = 2'd1,
    SHIFT     = 2'd2,
    DONE      = 2'd3
  } prog_state_e;

  // Default instruction memory geometry: two 16-bit constants plus eight
  // state words of 12 bits (condition, output and action fields).
  localparam int DEF_INPUT_WIDTH   = 1;
  localparam int DEF_STATE_COUNT   = 8;
  localparam int DEF_COND_WIDTH    = 4;
  localparam int DEF_OUTPUT_WIDTH  = 4;
  localparam int DEF_ACTION_WIDTH  = 4;
  localparam int DEF_COUNTER_WIDTH = 16;
  localparam int DEF_COUNTER_COUNT = 2;

  // Total image bits, padded up to a whole number of shift chunks.
  function automatic int calc_mem_width(
    input int input_width,
    input int state_count,
    input int cond_width,
    input int output_width,
    input int action_width,
    input int counter_width,
    input int counter_count
  );
    int raw;
    raw = counter_count * counter_width
        + state_count * (cond_width + output_width + action_width);
    if (input_width > 0 && (raw % input_width) != 0)
      raw = raw + input_width - (raw % input_width);
    return raw;
  endfunction

  localparam int DEF_MEM_WIDTH = calc_mem_width(
    DEF_INPUT_WIDTH, DEF_STATE_COUNT, DEF_COND_WIDTH, DEF_OUTPUT_WIDTH,
    DEF_ACTION_WIDTH, DEF_COUNTER_WIDTH, DEF_COUNTER_COUNT);

endpackage

// File: rtl/prog_serializer.sv
// Byte buffer that presents its top INPUT_WIDTH bits as the current chunk and
// shifts left one chunk per shift request. load has priority over shift so a
// new byte can replace the final chunk of the previous one with no bubble.
module prog_serializer #(
  parameter int INPUT_WIDTH = 1,
  parameter int BYTE_WIDTH  = 8
) (
  input  logic                   clock,
  input  logic                   rst_n,
  input  logic                   load,
  input  logic                   shift,
  input  logic [BYTE_WIDTH-1:0]  load_data,
  output logic [INPUT_WIDTH-1:0] chunk,
  output logic                   last_chunk
);

  localparam int CHUNKS = BYTE_WIDTH / INPUT_WIDTH;
  localparam int IDX_W  = (CHUNKS > 1) ? $clog2(CHUNKS) : 1;

  logic [BYTE_WIDTH-1:0] byte_buf;
  logic [IDX_W-1:0]      chunk_idx;

  // Capture a new byte or advance one chunk through the current byte.
  always_ff @(posedge clock or negedge rst_n) begin
    if (!rst_n) begin
      byte_buf  <= '0;
      chunk_idx <= '0;
    end else if (load) begin
      byte_buf  <= load_data;
      chunk_idx <= '0;
    end else if (shift) begin
      byte_buf  <= byte_buf << INPUT_WIDTH;
      chunk_idx <= chunk_idx + IDX_W'(1);
    end
  end

  assign chunk      = byte_buf[BYTE_WIDTH-1 -: INPUT_WIDTH];
  assign last_chunk = (chunk_idx == IDX_W'(CHUNKS - 1));

endmodule

// File: rtl/prog_loader.sv
// Host-side transmitter for the instruction memory serial programming port.
// Stream handshake: a byte transfers on a rising clock edge where
// in_valid && in_ready; in_ready never depends on in_valid, and it is held low
// whenever abort is high so an aborted byte is never consumed.
// Bytes are serialized MSB-first; exactly MEM_WIDTH bits are shifted per load
// and any leftover low bits of the final byte are dropped.
module prog_loader
  import prog_pkg::*;
#(
  parameter int INPUT_WIDTH = 1,
  parameter int BYTE_WIDTH  = 8,
  parameter int MEM_WIDTH   = DEF_MEM_WIDTH
) (
  input  logic                   clock,
  input  logic                   rst_n,
  input  logic                   start,
  input  logic                   abort,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [BYTE_WIDTH-1:0]  in_data,
  output logic                   prog_enable,
  output logic [INPUT_WIDTH-1:0] prog_data,
  output logic                   busy,
  output logic                   done,
  output logic                   loaded,
  output prog_state_e            state_dbg
);

  localparam int CNT_WIDTH = $clog2(MEM_WIDTH + 1);
  localparam int CMP_WIDTH = CNT_WIDTH + 1;

  if ((BYTE_WIDTH % INPUT_WIDTH) != 0 || (MEM_WIDTH % INPUT_WIDTH) != 0) begin : g_bad_width
    $error("prog_loader: INPUT_WIDTH must divide both BYTE_WIDTH and MEM_WIDTH");
  end

  prog_state_e            state_q, state_d;
  logic [CNT_WIDTH-1:0]   bit_cnt;
  logic                   loaded_q;
  logic                   ser_load, ser_shift, last_chunk;
  logic                   cnt_clr, cnt_inc, set_loaded, clr_loaded;
  logic                   last_bit;
  logic [INPUT_WIDTH-1:0] chunk;

  prog_serializer #(
    .INPUT_WIDTH (INPUT_WIDTH),
    .BYTE_WIDTH  (BYTE_WIDTH)
  ) u_serializer (
    .clock      (clock),
    .rst_n      (rst_n),
    .load       (ser_load),
    .shift      (ser_shift),
    .load_data  (in_data),
    .chunk      (chunk),
    .last_chunk (last_chunk)
  );

  // The chunk on the wire this cycle completes the image.
  assign last_bit = ({1'b0, bit_cnt} + CMP_WIDTH'(INPUT_WIDTH)) == CMP_WIDTH'(MEM_WIDTH);

  // Next-state and per-cycle controls; abort outranks everything outside IDLE.
  always_comb begin
    state_d     = state_q;
    in_ready    = 1'b0;
    prog_enable = 1'b0;
    done        = 1'b0;
    ser_load    = 1'b0;
    ser_shift   = 1'b0;
    cnt_clr     = 1'b0;
    cnt_inc     = 1'b0;
    set_loaded  = 1'b0;
    clr_loaded  = 1'b0;
    case (state_q)
      IDLE: begin
        if (start && !abort) begin
          state_d    = WAIT_BYTE;
          cnt_clr    = 1'b1;
          clr_loaded = 1'b1;
        end
      end
      WAIT_BYTE: begin
        if (abort) begin
          state_d    = IDLE;
          clr_loaded = 1'b1;
        end else begin
          in_ready = 1'b1;
          if (in_valid) begin
            ser_load = 1'b1;
            state_d  = SHIFT;
          end
        end
      end
      SHIFT: begin
        prog_enable = 1'b1;
        ser_shift   = 1'b1;
        cnt_inc     = 1'b1;
        if (abort) begin
          state_d    = IDLE;
          clr_loaded = 1'b1;
        end else if (last_bit) begin
          state_d    = DONE;
          set_loaded = 1'b1;
        end else if (last_chunk) begin
          in_ready = 1'b1;
          if (in_valid) ser_load = 1'b1;
          else          state_d  = WAIT_BYTE;
        end
      end
      DONE: begin
        state_d = IDLE;
        if (abort) clr_loaded = 1'b1;
        else       done       = 1'b1;
      end
      default: state_d = IDLE;
    endcase
  end

  // State register, shifted-bit counter and the loaded flag.
  always_ff @(posedge clock or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      bit_cnt  <= '0;
      loaded_q <= 1'b0;
    end else begin
      state_q <= state_d;
      if (cnt_clr)      bit_cnt <= '0;
      else if (cnt_inc) bit_cnt <= bit_cnt + CNT_WIDTH'(INPUT_WIDTH);
      if (clr_loaded)      loaded_q <= 1'b0;
      else if (set_loaded) loaded_q <= 1'b1;
    end
  end

  assign prog_data = (state_q == SHIFT) ? chunk : '0;
  assign busy      = (state_q != IDLE);
  assign loaded    = loaded_q;
  assign state_dbg = state_q;

endmodule

// File: tb/tb_prog_loader.sv
// Directed bench for prog_loader: a default 128-bit/1-bit instance and a
// 12-bit/2-bit instance, each with a model of the instruction memory shift
// register that records every strobe.
module tb_prog_loader;
  import prog_pkg::*;

  // ---------------- clock / reset ----------------
  logic clock = 1'b0;
  logic rst_n = 1'b0;
  always #5 clock = ~clock;

  int cyc = 0;
  always @(posedge clock) cyc <= cyc + 1;

  // ---------------- DUT a: default parameters ----------------
  logic        start_a, abort_a, in_valid_a, in_ready_a;
  logic [7:0]  in_data_a;
  logic        prog_enable_a, busy_a, done_a, loaded_a;
  logic [0:0]  prog_data_a;
  prog_state_e state_a;

  prog_loader u_dut_a (
    .clock       (clock),
    .rst_n       (rst_n),
    .start       (start_a),
    .abort       (abort_a),
    .in_valid    (in_valid_a),
    .in_ready    (in_ready_a),
    .in_data     (in_data_a),
    .prog_enable (prog_enable_a),
    .prog_data   (prog_data_a),
    .busy        (busy_a),
    .done        (done_a),
    .loaded      (loaded_a),
    .state_dbg   (state_a)
  );

  // ---------------- DUT b: 2-bit chunks, 12-bit image ----------------
  logic        start_b, abort_b, in_valid_b, in_ready_b;
  logic [7:0]  in_data_b;
  logic        prog_enable_b, busy_b, done_b, loaded_b;
  logic [1:0]  prog_data_b;
  prog_state_e state_b;

  prog_loader #(.INPUT_WIDTH(2), .BYTE_WIDTH(8), .MEM_WIDTH(12)) u_dut_b (
    .clock       (clock),
    .rst_n       (rst_n),
    .start       (start_b),
    .abort       (abort_b),
    .in_valid    (in_valid_b),
    .in_ready    (in_ready_b),
    .in_data     (in_data_b),
    .prog_enable (prog_enable_b),
    .prog_data   (prog_data_b),
    .busy        (busy_b),
    .done        (done_b),
    .loaded      (loaded_b),
    .state_dbg   (state_b)
  );

  // ---------------- memory models / monitors ----------------
  logic         mon_clr = 1'b0;
  logic [127:0] img_a;
  int           n_strobe_a, n_done_a, first_a, last_a;
  logic [0:0]   obs_a_q[$];
  logic [11:0]  img_b;
  int           n_strobe_b, n_done_b;
  logic [1:0]   obs_b_q[$];

  // Record every strobe and done pulse of both instances.
  always @(posedge clock) begin
    if (mon_clr) begin
      img_a <= '0; n_strobe_a <= 0; n_done_a <= 0; first_a <= -1; last_a <= -1;
      obs_a_q.delete();
      img_b <= '0; n_strobe_b <= 0; n_done_b <= 0;
      obs_b_q.delete();
    end else begin
      if (prog_enable_a) begin
        img_a <= {img_a[126:0], prog_data_a};
        if (n_strobe_a == 0) first_a <= cyc;
        last_a <= cyc;
        n_strobe_a <= n_strobe_a + 1;
        obs_a_q.push_back(prog_data_a);
      end
      if (done_a) n_done_a <= n_done_a + 1;
      if (prog_enable_b) begin
        img_b <= {img_b[9:0], prog_data_b};
        n_strobe_b <= n_strobe_b + 1;
        obs_b_q.push_back(prog_data_b);
      end
      if (done_b) n_done_b <= n_done_b + 1;
    end
  end

  // ---------------- scoreboard ----------------
  int           checks = 0;
  int           errors = 0;
  logic [0:0]   exp_q[$];
  logic [1:0]   exp_b_q[$];
  logic [7:0]   img_bytes [16];
  logic [127:0] exp_img;

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic int seq_mismatch_a();
    int m = 0;
    if (obs_a_q.size() != exp_q.size()) m++;
    for (int i = 0; i < exp_q.size(); i++)
      if (i >= obs_a_q.size() || obs_a_q[i] !== exp_q[i]) m++;
    return m;
  endfunction

  function automatic int seq_mismatch_b();
    int m = 0;
    if (obs_b_q.size() != exp_b_q.size()) m++;
    for (int i = 0; i < exp_b_q.size(); i++)
      if (i >= obs_b_q.size() || obs_b_q[i] !== exp_b_q[i]) m++;
    return m;
  endfunction

  // ---------------- driver tasks ----------------
  task automatic clear_monitor();
    @(negedge clock);
    mon_clr = 1'b1;
    @(posedge clock);
    #1 mon_clr = 1'b0;
  endtask

  task automatic start_pulse_a();
    @(negedge clock);
    start_a = 1'b1;
    @(posedge clock);
    #1 start_a = 1'b0;
  endtask

  // Hold the byte valid until the DUT is ready, then complete the transfer.
  task automatic send_byte_a(input logic [7:0] b, output bit ok);
    in_valid_a = 1'b1;
    in_data_a  = b;
    ok = 1'b0;
    for (int t = 0; t < 64 && !ok; t++) begin
      @(negedge clock);
      if (in_ready_a) ok = 1'b1;
    end
    @(posedge clock);
    #1 in_valid_a = 1'b0;
  endtask

  task automatic send_byte_b(input logic [7:0] b, output bit ok);
    in_valid_b = 1'b1;
    in_data_b  = b;
    ok = 1'b0;
    for (int t = 0; t < 64 && !ok; t++) begin
      @(negedge clock);
      if (in_ready_b) ok = 1'b1;
    end
    @(posedge clock);
    #1 in_valid_b = 1'b0;
  endtask

  task automatic push_byte_exp(input logic [7:0] b);
    for (int k = 7; k >= 0; k--) exp_q.push_back(b[k]);
  endtask

  // Full 16-byte load; gap = idle cycles after each handshake before the next byte.
  task automatic load_a(input string tag, input int gap, input int exp_span);
    bit ok;
    int hs_fail = 0;
    logic [7:0] f8;
    clear_monitor();
    exp_q.delete();
    exp_img = '0;
    for (int i = 0; i < 16; i++) begin
      exp_img = {exp_img[119:0], img_bytes[i]};
      push_byte_exp(img_bytes[i]);
    end
    start_pulse_a();
    for (int i = 0; i < 16; i++) begin
      send_byte_a(img_bytes[i], ok);
      if (!ok) hs_fail++;
      if (i == 0) chk({tag, "_first_chunk_latency"}, {prog_enable_a, prog_data_a}, {1'b1, img_bytes[0][7]});
      if (i < 15) repeat (gap) @(posedge clock);
      if (i < 15 && gap > 0) #1;
    end
    for (int t = 0; t < 40 && busy_a; t++) @(negedge clock);
    repeat (2) @(negedge clock);
    chk({tag, "_handshake_timeouts"}, hs_fail, 0);
    chk({tag, "_strobes"}, n_strobe_a, 128);
    chk({tag, "_strobe_span"}, last_a - first_a + 1, exp_span);
    f8 = '0;
    for (int i = 0; i < 8; i++) f8 = {f8[6:0], (i < obs_a_q.size()) ? obs_a_q[i] : 1'bx};
    chk({tag, "_first8"}, f8, 8'hA5);
    chk({tag, "_chunk_seq"}, seq_mismatch_a(), 0);
    chk({tag, "_image"}, img_a, exp_img);
    chk({tag, "_image_msbyte"}, img_a[127:120], 8'hA5);
    chk({tag, "_done_count"}, n_done_a, 1);
    chk({tag, "_idle_outputs"}, {loaded_a, busy_a, in_ready_a, prog_enable_a}, 4'b1000);
  endtask

  // ---------------- directed sequence ----------------
  initial begin
    bit ok, ok2;
    int rdy_seen;
    start_a = 0; abort_a = 0; in_valid_a = 0; in_data_a = '0;
    start_b = 0; abort_b = 0; in_valid_b = 0; in_data_b = '0;
    img_bytes[0] = 8'hA5;
    for (int i = 1; i < 16; i++) img_bytes[i] = 8'(i * 29 + 49);

    // Reset state
    #12;
    chk("reset_a_outputs", {busy_a, prog_enable_a, in_ready_a, done_a, loaded_a, prog_data_a}, '0);
    chk("reset_b_outputs", {busy_b, prog_enable_b, in_ready_b, done_b, loaded_b, prog_data_b}, '0);
    chk("reset_a_state", state_a, IDLE);
    rst_n = 1'b1;

    // start and abort together in IDLE: abort wins
    @(negedge clock);
    start_a = 1'b1; abort_a = 1'b1;
    @(posedge clock);
    #1 start_a = 1'b0; abort_a = 1'b0;
    chk("start_abort_idle_busy", {busy_a, state_a}, {1'b0, IDLE});

    // Back-to-back full load, then the same load with 3-cycle strobe gaps
    load_a("b2b", 0, 128);
    load_a("gap", 10, 173);

    // 2-bit chunks, 12-bit image: 0xB4 -> 2,3,1,0; 0x3C -> 0,3 then dropped
    clear_monitor();
    exp_b_q = '{2'd2, 2'd3, 2'd1, 2'd0, 2'd0, 2'd3};
    @(negedge clock);
    start_b = 1'b1;
    @(posedge clock);
    #1 start_b = 1'b0;
    send_byte_b(8'hB4, ok);
    chk("b_first_chunk", {prog_enable_b, prog_data_b}, {1'b1, 2'd2});
    send_byte_b(8'h3C, ok2);
    chk("b_handshakes", {ok, ok2}, 2'b11);
    chk("b_second_byte_chunk0", {prog_enable_b, prog_data_b, in_ready_b}, {1'b1, 2'd0, 1'b0});
    @(posedge clock); #1;
    chk("b_second_byte_chunk1", {prog_enable_b, prog_data_b, in_ready_b}, {1'b1, 2'd3, 1'b0});
    @(posedge clock); #1;
    in_valid_b = 1'b1; in_data_b = 8'hFF;
    chk("b_done_cycle", {done_b, prog_enable_b, loaded_b, in_ready_b}, 4'b1010);
    @(posedge clock); #1;
    chk("b_after_done", {done_b, busy_b, loaded_b, in_ready_b}, 4'b0010);
    rdy_seen = 0;
    for (int t = 0; t < 4; t++) begin
      @(negedge clock);
      if (in_ready_b) rdy_seen++;
    end
    in_valid_b = 1'b0;
    chk("b_no_accept_in_idle", rdy_seen, 0);
    chk("b_strobes", n_strobe_b, 6);
    chk("b_chunk_seq", seq_mismatch_b(), 0);
    chk("b_image", img_b, 12'hB43);
    chk("b_done_count", n_done_b, 1);

    // Abort on the 40th strobe with a byte offered in the same cycle
    clear_monitor();
    exp_q.delete();
    for (int i = 0; i < 5; i++) push_byte_exp(img_bytes[i]);
    start_pulse_a();
    rdy_seen = 0;
    for (int i = 0; i < 5; i++) begin
      if (i == 2) start_a = 1'b1;
      send_byte_a(img_bytes[i], ok);
      start_a = 1'b0;
      if (!ok) rdy_seen++;
    end
    chk("abort_handshake_timeouts", rdy_seen, 0);
    repeat (7) @(posedge clock);
    #1 abort_a = 1'b1; in_valid_a = 1'b1; in_data_a = 8'hFF;
    #1;
    chk("abort_cycle_strobe", {prog_enable_a, in_ready_a}, 2'b10);
    @(posedge clock);
    #1 abort_a = 1'b0; in_valid_a = 1'b0;
    chk("abort_next_cycle", {prog_enable_a, busy_a, loaded_a, done_a}, 4'b0000);
    repeat (3) @(negedge clock);
    chk("abort_strobes", n_strobe_a, 40);
    chk("abort_no_done", n_done_a, 0);
    chk("abort_chunk_seq", seq_mismatch_a(), 0);
    chk("abort_state", state_a, IDLE);

    // A later full load still works
    load_a("post_abort", 0, 128);

    // Async reset between edges while shifting
    clear_monitor();
    start_pulse_a();
    send_byte_a(8'h5A, ok);
    repeat (3) @(posedge clock);
    #3;
    chk("pre_reset_shifting", {prog_enable_a, busy_a, loaded_a}, 3'b110);
    rst_n = 1'b0;
    #1;
    chk("async_reset_drop", {prog_enable_a, busy_a, in_ready_a, loaded_a}, 4'b0000);
    @(negedge clock);
    rst_n = 1'b1;
    load_a("post_reset", 0, 128);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  // Hard time limit so the run always ends.
  initial begin
    #200000;
    errors++;
    $display("FAIL watchdog observed=timeout expected=finish");
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $fatal(1, "watchdog expired");
  end

endmodule
